// File: rtl/prio_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prio_arb_pkg
// Description : Shared mode encodings and the round-robin pointer wrap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package prio_arb_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Explicit wrap so non-power-of-2 widths return to 0 after N-1.
   function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prio_enc_core.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_core
// Description : Combinational rotate / priority-search / un-rotate encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_core #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   input  logic             up,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [N-1:0]     w_rot;
   logic [IDX_W-1:0] w_k;

   // Position of the k-th candidate, walking from start upward or downward mod N.
   function automatic logic [IDX_W-1:0] pos_of(input logic [IDX_W-1:0] s,
                                                input int unsigned k,
                                                input logic dir_up);
      int unsigned p;
      if (dir_up)
         p = (32'(s) + k) % N;
      else
         p = (32'(s) + N - k) % N;
      return IDX_W'(p);
   endfunction

   for (genvar k = 0; k < N; k++) begin : g_rot
      assign w_rot[k] = req[pos_of(start, k, up)];
   end

   always_comb begin
      w_k = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k])
            w_k = IDX_W'(k);
      end
   end

   assign found = |req;
   assign idx   = pos_of(start, 32'(w_k), up);

endmodule
`default_nettype wire

// File: rtl/prio_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : prio_arbiter_rr
// Description : N-input fixed/round-robin arbiter with a valid/ready result reg.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_arbiter_rr
   import prio_arb_pkg::*;
#(
   parameter int N = 8,
   localparam int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             mode,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   output logic [N-1:0]     out_onehot,
   output logic [IDX_W-1:0] rr_ptr
);

   localparam logic [N-1:0]     c_one  = N'(1);
   localparam logic [IDX_W-1:0] c_top  = IDX_W'(N - 1);

   logic             r_valid;
   logic [IDX_W-1:0] r_idx;
   logic [N-1:0]     r_onehot;
   logic [IDX_W-1:0] r_ptr;

   logic             w_rr;
   logic [IDX_W-1:0] w_start;
   logic             w_found;
   logic [IDX_W-1:0] w_idx;
   logic             w_load;

   // Fixed priority is a downward search from the top index; RR searches up from r_ptr.
   assign w_rr    = (mode == MODE_RR);
   assign w_start = w_rr ? r_ptr : c_top;

   prio_enc_core #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_core (
      .req   (req),
      .start (w_start),
      .up    (w_rr),
      .found (w_found),
      .idx   (w_idx)
   );

   assign w_load = (!r_valid || out_ready) && w_found;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid  <= 1'b0;
         r_idx    <= '0;
         r_onehot <= '0;
         r_ptr    <= '0;
      end else begin
         if (w_load) begin
            r_valid  <= 1'b1;
            r_idx    <= w_idx;
            r_onehot <= c_one << w_idx;
            if (w_rr)
               r_ptr <= IDX_W'(next_ptr(32'(w_idx), N));
         end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid  = r_valid;
   assign out_idx    = r_idx;
   assign out_onehot = r_onehot;
   assign rr_ptr     = r_ptr;

endmodule
`default_nettype wire
